// File: rtl/bp_nonsynth_load_sequencer.sv
// Sequences the NBF loader, then the CCE cfg loader, onto one host I/O link.
// Optional watchdog enabled by defining BP_LOAD_SEQ_TIMEOUT_EN.
module bp_nonsynth_load_sequencer #(
  parameter int msg_width_p       = 64,
  parameter int max_outstanding_p = 8,
  parameter int skip_nbf_p        = 0,
  parameter int timeout_p         = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [msg_width_p-1:0] nbf_cmd_i,
  input  logic                   nbf_cmd_v_i,
  output logic                   nbf_cmd_yumi_o,
  output logic [msg_width_p-1:0] nbf_resp_o,
  output logic                   nbf_resp_v_o,
  input  logic                   nbf_resp_ready_i,
  input  logic                   nbf_done_i,
  input  logic [msg_width_p-1:0] cfg_cmd_i,
  input  logic                   cfg_cmd_v_i,
  output logic                   cfg_cmd_yumi_o,
  output logic [msg_width_p-1:0] cfg_resp_o,
  output logic                   cfg_resp_v_o,
  input  logic                   cfg_resp_ready_i,
  output logic                   cfg_reset_o,
  output logic [msg_width_p-1:0] load_cmd_o,
  output logic                   load_cmd_v_o,
  input  logic                   load_cmd_ready_i,
  input  logic [msg_width_p-1:0] load_resp_i,
  input  logic                   load_resp_v_i,
  output logic                   load_resp_yumi_o,
  output logic [1:0]             phase_o,
  output logic                   error_o
);

  localparam int cnt_w_lp = $clog2(max_outstanding_p + 1);
  localparam logic [cnt_w_lp-1:0] max_lp = cnt_w_lp'(max_outstanding_p);

  typedef enum logic [1:0] {
    e_nbf   = 2'd0,
    e_drain = 2'd1,
    e_cfg   = 2'd2
  } state_e;

  localparam state_e reset_state_lp = (skip_nbf_p != 0) ? e_cfg : e_nbf;

  state_e                state_q, state_d;
  logic [cnt_w_lp-1:0]   count_q, count_d;
  logic                  cfg_reset_q, cfg_reset_d;
  logic                  error_q, error_d;
  logic                  src_v, cmd_hs, resp_dec, owner_cfg, wd_trip;

  // Command path: the active phase picks the source; DRAIN issues nothing
  always_comb begin
    src_v = 1'b0;
    case (state_q)
      e_nbf:   src_v = nbf_cmd_v_i;
      e_cfg:   src_v = cfg_cmd_v_i;
      default: src_v = 1'b0;
    endcase
  end

  assign load_cmd_v_o   = ~reset_i & src_v & (count_q < max_lp);
  assign load_cmd_o     = (state_q == e_cfg) ? cfg_cmd_i : nbf_cmd_i;
  assign cmd_hs         = load_cmd_v_o & load_cmd_ready_i;
  assign nbf_cmd_yumi_o = cmd_hs & (state_q == e_nbf);
  assign cfg_cmd_yumi_o = cmd_hs & (state_q == e_cfg);

  assign owner_cfg        = (state_q == e_cfg);
  assign nbf_resp_o       = load_resp_i;
  assign cfg_resp_o       = load_resp_i;
  assign nbf_resp_v_o     = ~reset_i & load_resp_v_i & ~owner_cfg;
  assign cfg_resp_v_o     = ~reset_i & load_resp_v_i & owner_cfg;
  assign load_resp_yumi_o = ~reset_i & load_resp_v_i
                          & (owner_cfg ? cfg_resp_ready_i : nbf_resp_ready_i);

  // A response with nothing outstanding is dropped without touching count
  assign resp_dec = load_resp_yumi_o & (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({cmd_hs, resp_dec})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    state_d = state_q;
    case (state_q)
      e_nbf:   if (nbf_done_i) state_d = e_drain;
      e_drain: if (count_q == '0) state_d = e_cfg;
      default: state_d = state_q;
    endcase

    cfg_reset_d = (state_d != e_cfg);
    error_d     = error_q
                | (load_resp_v_i & (count_q == '0))
                | (nbf_cmd_v_i & (state_q == e_cfg))
                | wd_trip;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= reset_state_lp;
      count_q     <= '0;
      cfg_reset_q <= (skip_nbf_p == 0);
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      cfg_reset_q <= cfg_reset_d;
      error_q     <= error_d;
    end
  end

`ifdef BP_LOAD_SEQ_TIMEOUT_EN
  localparam int wd_w_lp = $clog2(timeout_p + 1);
  localparam logic [wd_w_lp-1:0] timeout_lp = wd_w_lp'(timeout_p);

  logic [wd_w_lp-1:0] wd_q, wd_d;
  logic               wd_reported_q;

  assign wd_trip = (wd_q == timeout_lp);

  // Watchdog only runs while something is outstanding and no response arrives
  always_comb begin
    wd_d = wd_q;
    if ((count_q == '0) || load_resp_yumi_o) wd_d = '0;
    else if (!wd_trip)                       wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wd_q          <= '0;
      wd_reported_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      if (wd_trip && !wd_reported_q) begin
        $display("load_sequencer watchdog: phase=%0d count=%0d", state_q, count_q);
        wd_reported_q <= 1'b1;
      end
    end
  end
`else
  assign wd_trip = 1'b0;
`endif

  assign cfg_reset_o = cfg_reset_q;
  assign phase_o     = state_q;
  assign error_o     = error_q;

endmodule
